// File: rtl/io_responder_if.sv
// -----------------------------------------------------------------------------
// io_responder_if
// CPU-side I/O bus between the control unit / datapath and io_responder.
//
// Signals:
//   iom_in    1   I/O space select (1 = I/O access)
//   wen_in    1   active-low write enable (0 = write)
//   addr_in   16  I/O address
//   data_in   16  write data
//   data_out  16  combinational read data back to the MD mux
//
// Modports:
//   master - CPU / datapath side (drives the cycle, receives read data)
//   slave  - peripheral side (io_responder)
// -----------------------------------------------------------------------------
interface io_responder_if;
    logic        iom_in;
    logic        wen_in;
    logic [15:0] addr_in;
    logic [15:0] data_in;
    logic [15:0] data_out;

    modport master (
        output iom_in,
        output wen_in,
        output addr_in,
        output data_in,
        input  data_out
    );

    modport slave (
        input  iom_in,
        input  wen_in,
        input  addr_in,
        input  data_in,
        output data_out
    );
endinterface : io_responder_if

// File: rtl/io_responder.sv
// -----------------------------------------------------------------------------
// io_responder
// Memory-mapped I/O peripheral answering the CPU's IOR/IOW cycles.
//
// Register map (selected when iom_in=1 and addr_in[15:2]=0):
//   0 TXDATA  W: push into TX FIFO          R: FIFO count (zero-extended)
//   1 RXPORT  W: ignored                    R: captured port_in
//   2 STATUS  W: bit0 flush, bit1 clear ovf R: {12'b0, ovf, full, empty, valid}
//   3 GPO     R/W general-purpose output register
//
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   bus            io_responder_if.slave (iom_in, wen_in, addr_in, data_in,
//                  data_out)
//   tx_data_out    FIFO head word (0 when empty)
//   tx_valid_out   FIFO non-empty
//   tx_ready_in    consumer accepts the head word this cycle
//   port_in        asynchronous external input port
//   gpo_out        general-purpose output register
//
// Optional feature: define IO_RX_SYNC_EN to pass port_in through a 2-flop
// synchronizer (2-edge latency); otherwise a single capture register is used
// (1-edge latency).
// -----------------------------------------------------------------------------
module io_responder #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] GPO_RST    = 16'h0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    io_responder_if.slave        bus,
    output logic [15:0]          tx_data_out,
    output logic                 tx_valid_out,
    input  logic                 tx_ready_in,
    input  logic [15:0]          port_in,
    output logic [15:0]          gpo_out
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        A_TXDATA = 2'd0,
        A_RXPORT = 2'd1,
        A_STATUS = 2'd2,
        A_GPO    = 2'd3
    } reg_addr_e;

    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   gpo_q, gpo_d;
    logic [15:0]   rx_q;

    logic      sel, wr;
    reg_addr_e reg_addr;
    logic      push, push_ok, pop, flush, clr_ovf, gpo_wr;
    logic      full, empty;

    // ---------------- decode ----------------
    assign sel      = bus.iom_in && (bus.addr_in[15:2] == 14'd0);
    assign wr       = sel && !bus.wen_in;
    assign reg_addr = reg_addr_e'(bus.addr_in[1:0]);

    assign push    = wr && (reg_addr == A_TXDATA);
    assign flush   = wr && (reg_addr == A_STATUS) && bus.data_in[0];
    assign clr_ovf = wr && (reg_addr == A_STATUS) && bus.data_in[1];
    assign gpo_wr  = wr && (reg_addr == A_GPO);

    assign full    = (cnt_q == CW'(FIFO_DEPTH));
    assign empty   = (cnt_q == '0);
    assign pop     = tx_valid_out && tx_ready_in;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push_ok = push && (!full || pop);

    assign tx_valid_out = !empty;
    assign tx_data_out  = empty ? 16'h0000 : mem_q[rd_ptr_q];
    assign gpo_out      = gpo_q;

    // ---------------- next state ----------------
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would infer a latch.
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        gpo_d    = gpo_q;

        if (flush) begin
            // Flush beats a concurrent pop; a concurrent push cannot occur.
            cnt_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_ok && !pop)      cnt_d = cnt_q + 1'b1;
            else if (!push_ok && pop) cnt_d = cnt_q - 1'b1;
        end

        if (push && !push_ok) ovf_d = 1'b1;
        if (clr_ovf)          ovf_d = 1'b0;
        if (gpo_wr)           gpo_d = bus.data_in;
    end

    // ---------------- state ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops
        // update together from pre-edge values.
        if (!rst_n) begin
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            gpo_q    <= GPO_RST;
        end else begin
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            gpo_q    <= gpo_d;
        end
    end

    // NOTE: the storage array has no reset; entries are only visible through
    // the count, and tx_data_out is forced to 0 while empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= bus.data_in;
    end

    // ---------------- input port capture ----------------
`ifdef IO_RX_SYNC_EN
    logic [15:0] rx_meta_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= '0;
            rx_q      <= '0;
        end else begin
            rx_meta_q <= port_in;
            rx_q      <= rx_meta_q;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_q <= '0;
        else        rx_q <= port_in;
    end
`endif

    // ---------------- read mux (no side effects) ----------------
    always_comb begin
        bus.data_out = 16'h0000;
        if (sel) begin
            unique case (reg_addr)
                A_TXDATA: bus.data_out = {{(16-CW){1'b0}}, cnt_q};
                A_RXPORT: bus.data_out = rx_q;
                A_STATUS: bus.data_out = {12'h000, ovf_q, full, empty, tx_valid_out};
                A_GPO:    bus.data_out = gpo_q;
            endcase
        end
    end
endmodule : io_responder

// File: doc/io_responder.md
Name: io_responder

Overview:
- Memory-mapped I/O peripheral that answers the CPU control unit's IOR/IOW cycles.
- The CPU does a read with iom=1 and md selecting I/O data, and a write with iom=1 and an active-low write-enable of 0.
- Contains four addressable registers:
  - a transmit FIFO draining to an external valid/ready consumer,
  - a synchronized input port,
  - a status/control register,
  - a general-purpose output register.
- Sits beside data memory on the datapath address/data buses.

Parameters:
FIFO_DEPTH, 4, TX FIFO entries; power of two, 2..16
GPO_RST, 16'h0000, reset value of the GPO output register

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
iom_in  in  1  I/O space select from CU (1 = I/O access)
wen_in  in  1  active-low write enable from CU (0 = write)
addr_in  in  16  I/O address from datapath
data_in  in  16  write data from datapath
data_out  out  16  read data to datapath MD mux (combinational)
tx_data_out  out  16  FIFO head word
tx_valid_out  out  1  FIFO non-empty
tx_ready_in  in  1  consumer accepts word this cycle
port_in  in  16  asynchronous external input port
gpo_out  out  16  general-purpose output register

Behaviour:
- Reset is asynchronous, active-low. On reset:
  - FIFO empty, pointers 0, overflow flag 0.
  - tx_valid_out=0, tx_data_out=0.
  - gpo_out=GPO_RST.
  - Sync stages 0.
  - data_out reflects the reset state.
- Reset asserted mid-transfer discards FIFO contents; there is no partial-word retention.
- Address decode:
  - Selected only when iom_in=1 and addr_in[15:2]=0.
  - Unselected reads return 16'h0000; unselected writes are ignored.
- Write strobe: iom_in=1 and wen_in=0 and selected. A write takes effect at the next rising clk edge; there are no wait states.
- Reads are combinational from registered state, so they are valid in the same cycle. A read has no side effects.
- Register map:
  - addr 0, TXDATA:
    - Write pushes data_in into the FIFO.
    - Read returns {zero-extended count}.
  - addr 1, RXPORT:
    - Read returns the synchronized port_in.
    - Write is ignored.
  - addr 2, STATUS:
    - Read returns {12'b0, ovf, full, empty, tx_valid_out}.
    - Write: bit0=1 flushes the FIFO (count←0); bit1=1 clears ovf. Other bits are ignored.
  - addr 3, GPO:
    - Read/write register driving gpo_out.
- FIFO:
  - pop = tx_valid_out && tx_ready_in; tx_data_out = mem[rd_ptr].
  - A push is accepted when count<FIFO_DEPTH or a pop occurs in the same cycle.
  - A rejected push sets ovf (sticky) and leaves contents unchanged.
  - Simultaneous accepted push and pop: count is unchanged and both pointers advance.
  - Push into an empty FIFO: there is no bypass. tx_valid_out rises the cycle after the write edge.
  - Pointers are log2(FIFO_DEPTH) bits wide and wrap modulo depth. count is log2(FIFO_DEPTH)+1 bits.
  - full = (count==FIFO_DEPTH); empty = (count==0).
  - Flush together with a push in the same write is impossible, because the two are at different addresses.
  - Flush together with a pop: flush wins, and the FIFO is empty next cycle.
  - tx_data_out is held stable while tx_valid_out=1 and tx_ready_in=0.
  - tx_data_out is 0 when empty.
- Write while wen_in=0 and iom_in=0: this is a memory write, and the block ignores it.

Optional Feature:
- IO_RX_SYNC_EN defined:
  - port_in passes through a 2-flop synchronizer.
  - RXPORT reflects a port_in change 2 edges after it is sampled.
- IO_RX_SYNC_EN undefined:
  - Single capture register.
  - RXPORT reflects the change after 1 edge.

Test Plan:
- Reset, then read addr 2 and addr 3 → STATUS=16'h0002 (empty), GPO=GPO_RST, tx_valid_out=0.
- tx_ready_in=0; write 16'hA001..A004 to addr 0 → count=4, STATUS=16'h0004|ready bits (full=1, valid=1). Fifth write 16'hA005 → ovf=1, contents unchanged. Then raise tx_ready_in → words drain in order A001..A004, one per cycle, then tx_valid_out=0.
- FIFO full with tx_ready_in=1 while writing 16'hBEEF to addr 0 → push accepted, ovf stays 0, count stays 4, BEEF emerges last.
- 6 pushes and 6 pops interleaved so both pointers wrap → order preserved. Then write 16'h0003 to addr 2 → empty=1, ovf=0 next cycle.
- port_in changes 0→16'h5A5A → RXPORT reads 5A5A after 2 edges with IO_RX_SYNC_EN, or after 1 edge without it. Write to addr 1 has no effect.
- Write 16'h1234 to addr 3 with iom_in=0 → gpo_out unchanged. Write with addr_in=16'h0007 → ignored, and the read returns 0. Assert rst_n low mid-drain → empty, tx_valid_out=0 immediately.
